// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS core front end: instruction-field bit
// positions, datapath width, default reset PC, the fetch FSM state type and
// a word-alignment helper.
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int INSTR_W    = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FETCH: request outstanding on the bus (imem_req=1)
  // WAIT : request granted, waiting for the response
  // HOLD : response captured in the hold buffer, IF/ID still stalled
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] a);
    return a & ~INSTR_W'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage_if
// Instruction-memory bus between the fetch stage (master) and the
// instruction memory (slave).
//
// Handshake: the master holds imem_req=1 with imem_addr until a cycle in
// which the slave answers imem_gnt=1; the request is accepted on that rising
// edge. imem_gnt is meaningful only while imem_req=1. The slave returns the
// word with a single-cycle imem_rvalid=1 pulse (imem_rdata valid in that
// cycle) no earlier than the cycle after the grant. At most one request is
// outstanding, so no new request is raised until the response has arrived.
//
// Signals: imem_req, imem_addr[31:0] (master -> slave)
//          imem_gnt, imem_rvalid, imem_rdata[31:0] (slave -> master)
// ---------------------------------------------------------------------------
interface instr_fetch_stage_if;
  import mips_pkg::*;

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register: instruction, its PC, PC+4 and a valid bit.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset (all fields -> 0)
//   load_i          write a new instruction (wins over flush and stall)
//   stall_i         ID cannot accept: keep the current contents
//   flush_i         kill the held instruction (valid -> 0)
//   instr_i, pc_i   new instruction and its address
//   valid_o, instr_o, pc_o, pc_plus4_o   register contents
//
// When neither loading nor stalled, the held instruction has moved on into
// ID, so the register turns into a bubble. Data fields are left untouched
// whenever valid drops; only the valid bit is meaningful then.
// ---------------------------------------------------------------------------
module ifid_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic [W-1:0] instr_i,
  input  logic [W-1:0] pc_i,
  output logic         valid_o,
  output logic [W-1:0] instr_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_plus4_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + W'(4);
    end else if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
// IF stage plus IF/ID register of the 32-bit MIPS core. Holds the PC, fetches
// one word at a time over the req/gnt/rvalid bus and presents instruction,
// PC, PC+4 and the opcode/funct fields to ID. Honours ID stall/flush and EX
// branch/jump redirects.
//
// Parameters:
//   INSTR_W   instruction / address width (32)
//   RESET_PC  PC loaded on reset (low two bits forced to 0)
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   stall_i, flush_i             ID-stage hold / kill of the IF/ID contents
//   redirect_valid, redirect_pc  restart fetch at redirect_pc (bits [1:0] ignored)
//   imem                         instruction-memory bus (master side)
//   id_valid, id_instr, id_pc, id_pc_plus4, id_opcode, id_funct   IF/ID outputs
//   perf_fetch_cnt, perf_squash_cnt   only with FETCH_PERF_CNT_EN defined
//   dbg_state                    current fetch FSM state
//
// Build option: define FETCH_PERF_CNT_EN to add the two performance counters
// (IF/ID loads, and squashed responses / discarded hold buffers).
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter int                  INSTR_W  = mips_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0]  RESET_PC = mips_pkg::DEFAULT_RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    redirect_valid,
  input  logic [INSTR_W-1:0]      redirect_pc,
  instr_fetch_stage_if.master     imem,
  output logic                    id_valid,
  output logic [INSTR_W-1:0]      id_instr,
  output logic [INSTR_W-1:0]      id_pc,
  output logic [INSTR_W-1:0]      id_pc_plus4,
  output logic [5:0]              id_opcode,
  output logic [5:0]              id_funct,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_squash_cnt,
`endif
  output mips_pkg::fetch_state_t  dbg_state
);

  import mips_pkg::*;

  fetch_state_t        state_q, state_d;
  logic [INSTR_W-1:0]  pc_q, pc_d;              // next address to request
  logic [INSTR_W-1:0]  req_pc_q, req_pc_d;      // address of the in-flight request
  logic [INSTR_W-1:0]  hold_instr_q, hold_instr_d;
  logic [INSTR_W-1:0]  hold_pc_q, hold_pc_d;
  logic                drop_q, drop_d;          // in-flight response is stale

  logic                ifid_load;
  logic [INSTR_W-1:0]  load_instr;
  logic [INSTR_W-1:0]  load_pc;
  logic                squash;
  logic                slot_free;
  logic [INSTR_W-1:0]  redirect_aligned;

  // IF/ID can take a new word if it is empty or its instruction leaves this cycle.
  assign slot_free        = !id_valid || !stall_i;
  assign redirect_aligned = align_word(redirect_pc);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    drop_d       = drop_q;
    ifid_load    = 1'b0;
    load_instr   = imem.imem_rdata;
    load_pc      = req_pc_q;
    squash       = 1'b0;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;

    case (state_q)
      FETCH: begin
        // Registers sit in FETCH during reset; keep the bus quiet until release.
        imem.imem_req = !rst;
        if (imem.imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + INSTR_W'(4);
          state_d  = WAIT;
        end
        if (redirect_valid) begin
          pc_d = redirect_aligned;
          // A request granted in the redirect cycle belongs to the old path.
          if (imem.imem_gnt) drop_d = 1'b1;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
          if (imem.imem_rvalid) begin
            // The stale response is arriving right now: throw it away here
            // instead of waiting for one that will never come.
            squash  = 1'b1;
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem.imem_rvalid) begin
          if (drop_q) begin
            squash  = 1'b1;
            drop_d  = 1'b0;
            state_d = FETCH;
          end else if (slot_free) begin
            ifid_load = 1'b1;
            state_d   = FETCH;
          end else begin
            hold_instr_d = imem.imem_rdata;
            hold_pc_d    = req_pc_q;
            state_d      = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_aligned;
          squash  = 1'b1;
          state_d = FETCH;
        end else if (slot_free) begin
          ifid_load  = 1'b1;
          load_instr = hold_instr_q;
          load_pc    = hold_pc_q;
          state_d    = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= align_word(RESET_PC);
      req_pc_q     <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      drop_q       <= drop_d;
    end
  end

  ifid_reg #(.W(INSTR_W)) u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ifid_load),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .instr_i    (load_instr),
    .pc_i       (load_pc),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4)
  );

  assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
  assign id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];
  assign dbg_state = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_squash_q, perf_squash_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q + 32'(ifid_load);
    perf_squash_d = perf_squash_q + 32'(squash);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q  <= '0;
      perf_squash_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_squash_q <= perf_squash_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_squash_cnt = perf_squash_q;
`else
  logic unused_squash;
  assign unused_squash = squash;
`endif

endmodule
